ula_multiciclo: RTL and testbench
=================================

// Module: ula_multiciclo
// PURPOSE
//  Datapath ALU directly downstream of the ALU control decoder: consumes its 3-bit operation code plus two operands.
//  and/or/add/sub/slt complete in 1 cycle; mul/div run an iterative shift-add / restoring engine over WIDTH cycles.
//  The core FSM issues work with inicio and holds (stalls) while ocupado=1, then captures resultado on pronto.
// PARAMETERS
//  WIDTH  32  operand/result width (>=4, even)
// PORTS
//  clock          in   1      single clock; all state on rising edge
//  reset          in   1      synchronous, active-high
//  inicio         in   1      start; samples sinalOperacao, opA, opB when accepted
//  sinalOperacao  in   3      000 and,001 or,010 add,011 mul,100 div,101 reserved,110 sub,111 slt
//  opA            in   WIDTH  operand A (dividend / multiplicand)
//  opB            in   WIDTH  operand B (divisor / multiplier)
//  resultado      out  WIDTH  result; mul: product[WIDTH-1:0]; div: quotient
//  resultadoAlto  out  WIDTH  mul: product[2W-1:W]; div: remainder; else 0
//  zero           out  1      resultado == 0, registered with resultado
//  erroDiv        out  1      div by zero flag, valid with pronto
//  ocupado        out  1      busy; inicio ignored while high
//  pronto         out  1      one-cycle pulse: results valid (held until next pronto)
// BEHAVIOUR
//  Reset: FSM=OCIOSO; resultado=0, resultadoAlto=0, zero=0, erroDiv=0, ocupado=0, pronto=0, counter=0.
//  Reset mid-operation aborts: no pronto, operands/results discarded, next edge idle.
//  FSM: OCIOSO -> (inicio & op in {011,100}) CALCULA -> counter reaches 0 -> FINALIZA -> OCIOSO.
//  Accept cycle = cycle 0 (OCIOSO & inicio). Operands sampled only then; later input changes ignored.
//  Single-cycle ops (000,001,010,110,111,101): outputs registered at end of cycle 0; pronto=1 in cycle 1; ocupado stays 0.
//   add/sub wrap modulo 2^WIDTH, no overflow flag. slt: signed compare, result 1 or 0.
//   101 reserved: resultado=0, zero=1, resultadoAlto=0.
//  mul/div (signed two's complement): cycle 0 latch |A|,|B|, result signs, counter=WIDTH.
//   ocupado=1 in cycles 1..WIDTH+1; CALCULA = cycles 1..WIDTH (one bit per cycle); FINALIZA = cycle WIDTH+1
//   applies sign correction and registers outputs; pronto=1 in cycle WIDTH+2 (ocupado=0 there).
//   mul: full 2W-bit signed product split across resultadoAlto:resultado.
//   div: quotient truncates toward zero; remainder takes sign of dividend.
//   div -2^(W-1) / -1: resultado=0x80000000 (wraps), resultadoAlto=0, erroDiv=0.
//   div by zero: no iteration skipped (same latency); resultado=all ones, resultadoAlto=opA, erroDiv=1, zero=0.
//  erroDiv cleared on every non-div completion. zero always reflects resultado only.
//  inicio while ocupado=1: ignored, no queuing. inicio in the cycle pronto=1: accepted (FSM idle).
//  Back-to-back single-cycle ops: one result per cycle, pronto high continuously.
//  Outputs hold last result between pronto pulses.
// TESTING (WIDTH=32)
//  1. reset, then and 0xF0F0F0F0 & 0xFF00FF00 -> cycle1 pronto, resultado=0xF000F000, ocupado never set.
//  2. add 0x7FFFFFFF+1 -> 0x80000000; sub 5-5 -> 0, zero=1; slt -1 vs 1 -> 1; slt 1 vs -1 -> 0.
//  3. mul -3 * 7 -> pronto at cycle 34, resultado=0xFFFFFFEB, resultadoAlto=0xFFFFFFFF; ocupado cycles 1..33.
//  4. div -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; div 9 / 0 -> 0xFFFFFFFF, rem 9, erroDiv=1.
//  5. inicio pulsed with new op during mul busy -> ignored; operands changed after accept -> result unchanged.
//  6. reset asserted at cycle 10 of div -> no pronto, outputs 0 next cycle; new add accepted right after.

Source files
------------

// File: rtl/ula_multiciclo.sv
// ula_multiciclo
//   Multi-cycle ALU fed by the ALU control decoder. and/or/add/sub/slt and the
//   reserved code finish in one cycle. Signed mul/div run an iterative
//   shift-add / restoring engine that retires one bit per cycle over WIDTH
//   cycles, then spend one extra cycle on sign correction.
//
// Ports
//   clock          single clock, all state on the rising edge
//   reset          synchronous, active-high
//   inicio         start request, accepted only while idle
//   sinalOperacao  000 and, 001 or, 010 add, 011 mul, 100 div,
//                  101 reserved, 110 sub, 111 slt
//   opA, opB       operands (A: multiplicand / dividend, B: multiplier / divisor)
//   resultado      result (mul: product low half, div: quotient)
//   resultadoAlto  mul: product high half, div: remainder, otherwise 0
//   zero           resultado == 0, registered together with resultado
//   erroDiv        division by zero, valid with pronto
//   ocupado        a mul/div is in flight; inicio is ignored
//   pronto         one-cycle pulse, results valid and held until the next one
module ula_multiciclo #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inicio,
    input  logic [2:0]       sinalOperacao,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] resultado,
    output logic [WIDTH-1:0] resultadoAlto,
    output logic             zero,
    output logic             erroDiv,
    output logic             ocupado,
    output logic             pronto
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] CALCULA  = 2'd1;
    localparam logic [1:0] FINALIZA = 2'd2;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic [1:0]       estado;
    logic [CW-1:0]    contador;

    // Iterative engine. mul: alto = partial product, baixo = multiplier
    // shifting out / product low bits shifting in. div: alto = partial
    // remainder, baixo = dividend shifting out / quotient bits shifting in.
    logic [WIDTH:0]   alto;
    logic [WIDTH-1:0] baixo;
    logic [WIDTH-1:0] operando_b;
    logic             eh_div;
    logic             sinal_a;
    logic             sinal_b;
    logic             div_zero;

    logic             aceita;
    logic             multiciclo;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] res_simples;
    logic [WIDTH:0]   soma;
    logic [WIDTH:0]   deslocado;
    logic [WIDTH:0]   tentativa;
    logic [WIDTH:0]   alto_prox;
    logic [WIDTH-1:0] baixo_prox;
    logic [2*WIDTH-1:0] produto;
    logic [2*WIDTH-1:0] produto_final;
    logic [WIDTH-1:0] quociente;
    logic [WIDTH-1:0] resto;
    logic [WIDTH-1:0] res_final;
    logic [WIDTH-1:0] alto_final;

    assign aceita     = (estado == OCIOSO) && inicio;
    assign multiciclo = (sinalOperacao == OP_MUL) || (sinalOperacao == OP_DIV);
    assign ocupado    = (estado != OCIOSO);

    // Magnitudes as unsigned WIDTH-bit values; -2^(WIDTH-1) maps to itself,
    // which is its correct unsigned magnitude.
    assign abs_a = opA[WIDTH-1] ? -opA : opA;
    assign abs_b = opB[WIDTH-1] ? -opB : opB;

    // NOTE: every signal written in always_comb gets a value on every path
    // (here a default first), otherwise synthesis infers a latch.
    always_comb begin
        res_simples = '0;
        case (sinalOperacao)
            OP_AND:  res_simples = opA & opB;
            OP_OR:   res_simples = opA | opB;
            OP_ADD:  res_simples = opA + opB;
            OP_SUB:  res_simples = opA - opB;
            OP_SLT:  res_simples = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
            default: res_simples = '0;
        endcase
    end

    // One iteration step of either engine.
    always_comb begin
        soma      = baixo[0] ? (alto + {1'b0, operando_b}) : alto;
        deslocado = {alto[WIDTH-1:0], baixo[WIDTH-1]};
        // deslocado < 2*divisor, so bit WIDTH of the difference is a clean borrow.
        tentativa = deslocado - {1'b0, operando_b};
        if (eh_div) begin
            if (!tentativa[WIDTH]) begin
                alto_prox  = tentativa;
                baixo_prox = {baixo[WIDTH-2:0], 1'b1};
            end else begin
                alto_prox  = deslocado;
                baixo_prox = {baixo[WIDTH-2:0], 1'b0};
            end
        end else begin
            alto_prox  = {1'b0, soma[WIDTH:1]};
            baixo_prox = {soma[0], baixo[WIDTH-1:1]};
        end
    end

    // Sign correction applied in FINALIZA. A zero divisor makes every trial
    // subtraction succeed, so the remainder ends as |A| and the sign fix-up
    // restores opA; only the quotient needs forcing to all ones.
    always_comb begin
        produto       = {alto[WIDTH-1:0], baixo};
        produto_final = (sinal_a ^ sinal_b) ? -produto : produto;
        quociente     = div_zero ? '1 : ((sinal_a ^ sinal_b) ? -baixo : baixo);
        resto         = sinal_a ? -alto[WIDTH-1:0] : alto[WIDTH-1:0];
        if (eh_div) begin
            res_final  = quociente;
            alto_final = resto;
        end else begin
            res_final  = produto_final[WIDTH-1:0];
            alto_final = produto_final[2*WIDTH-1:WIDTH];
        end
    end

    // NOTE: the engine registers carry no reset; they are loaded on every
    // accepted mul/div before being read, so a reset would only cost area.
    always_ff @(posedge clock) begin
        if (aceita && multiciclo) begin
            eh_div   <= (sinalOperacao == OP_DIV);
            sinal_a  <= opA[WIDTH-1];
            sinal_b  <= opB[WIDTH-1];
            div_zero <= (opB == '0);
            alto     <= '0;
            if (sinalOperacao == OP_DIV) begin
                baixo      <= abs_a;
                operando_b <= abs_b;
            end else begin
                baixo      <= abs_b;
                operando_b <= abs_a;
            end
        end else if (estado == CALCULA) begin
            alto  <= alto_prox;
            baixo <= baixo_prox;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado        <= OCIOSO;
            contador      <= '0;
            resultado     <= '0;
            resultadoAlto <= '0;
            zero          <= 1'b0;
            erroDiv       <= 1'b0;
            pronto        <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        if (multiciclo) begin
                            estado   <= CALCULA;
                            contador <= CW'(WIDTH);
                        end else begin
                            resultado     <= res_simples;
                            resultadoAlto <= '0;
                            zero          <= (res_simples == '0);
                            erroDiv       <= 1'b0;
                            pronto        <= 1'b1;
                        end
                    end
                end
                CALCULA: begin
                    contador <= contador - CW'(1);
                    if (contador == CW'(1)) begin
                        estado <= FINALIZA;
                    end
                end
                FINALIZA: begin
                    resultado     <= res_final;
                    resultadoAlto <= alto_final;
                    zero          <= (res_final == '0);
                    erroDiv       <= eh_div && div_zero;
                    pronto        <= 1'b1;
                    estado        <= OCIOSO;
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo
//   Self-checking bench for ula_multiciclo (WIDTH=32). Expected results are
//   queued when an operation is issued and compared, together with the cycle
//   pronto must appear in, whenever the DUT raises pronto.
module tb_ula_multiciclo;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         inicio;
    logic [2:0]   sinalOperacao;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic [W-1:0] resultado;
    logic [W-1:0] resultadoAlto;
    logic         zero;
    logic         erroDiv;
    logic         ocupado;
    logic         pronto;

    always #5 clock = ~clock;

    ula_multiciclo #(.WIDTH(W)) dut (
        .clock         (clock),
        .reset         (reset),
        .inicio        (inicio),
        .sinalOperacao (sinalOperacao),
        .opA           (opA),
        .opB           (opB),
        .resultado     (resultado),
        .resultadoAlto (resultadoAlto),
        .zero          (zero),
        .erroDiv       (erroDiv),
        .ocupado       (ocupado),
        .pronto        (pronto)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] alto;
        logic         zero;
        logic         erro;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] alto;
        logic         zero;
        logic         erro;
        int           ciclo;
        int           id;
    } esp_t;

    esp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ciclo  = 0;
    bit   ocupado_visto = 1'b0;

    task automatic check(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nome, atual, esperado);
        end
    endtask

    always @(posedge clock) ciclo <= ciclo + 1;

    always @(negedge clock) if (ocupado) ocupado_visto = 1'b1;

    // Scoreboard consumer.
    always @(negedge clock) begin
        if (!reset && pronto) begin
            if (sb.size() == 0) begin
                check("pronto_extra", 64'(pronto), 64'd0);
            end else begin
                esp_t e;
                e = sb.pop_front();
                check($sformatf("ciclo[%0d]", e.id), 64'(ciclo), 64'(e.ciclo));
                check($sformatf("res[%0d]", e.id), 64'(resultado), 64'(e.res));
                check($sformatf("alto[%0d]", e.id), 64'(resultadoAlto), 64'(e.alto));
                check($sformatf("flags[%0d]", e.id), 64'({zero, erroDiv}), 64'({e.zero, e.erro}));
            end
        end
    end

    // Called just after a rising edge; holds inicio for exactly one edge.
    task automatic dispara(input vec_t v, input int id, input bit registra);
        esp_t e;
        int   lat;
        lat = (v.op == 3'b011 || v.op == 3'b100) ? W + 2 : 1;
        e.res   = v.res;
        e.alto  = v.alto;
        e.zero  = v.zero;
        e.erro  = v.erro;
        e.ciclo = ciclo + lat;
        e.id    = id;
        if (registra) sb.push_back(e);
        inicio        = 1'b1;
        sinalOperacao = v.op;
        opA           = v.a;
        opB           = v.b;
        @(posedge clock);
        #1;
        inicio = 1'b0;
    endtask

    task automatic espera(input int limite);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limite) begin
            @(posedge clock);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            check("timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tab[19];
        vec_t v;
        int   ocup_err;

        tab[0]  = '{3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 1'b0, 1'b0};
        tab[1]  = '{3'b001, 32'h12340000, 32'h00005678, 32'h12345678, 32'h0, 1'b0, 1'b0};
        tab[2]  = '{3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b0};
        tab[3]  = '{3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b1, 1'b0};
        tab[4]  = '{3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0};
        tab[5]  = '{3'b111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b1, 1'b0};
        tab[6]  = '{3'b110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0};
        tab[7]  = '{3'b101, 32'h00000012, 32'h00000034, 32'h00000000, 32'h0, 1'b1, 1'b0};
        tab[8]  = '{3'b011, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0};
        tab[9]  = '{3'b011, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b1, 1'b0};
        tab[10] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
        tab[11] = '{3'b011, 32'h00012345, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
        tab[12] = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0};
        tab[13] = '{3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0};
        tab[14] = '{3'b100, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0, 1'b0};
        tab[15] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0};
        tab[16] = '{3'b100, 32'h00000009, 32'h00000000, 32'hFFFFFFFF, 32'h00000009, 1'b0, 1'b1};
        tab[17] = '{3'b100, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0, 1'b1};
        tab[18] = '{3'b000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};

        reset         = 1'b1;
        inicio        = 1'b0;
        sinalOperacao = 3'b000;
        opA           = '0;
        opB           = '0;

        // Reset state.
        @(negedge clock);
        check("reset_dados", {resultado, resultadoAlto}, 64'd0);
        check("reset_flags", 64'({zero, erroDiv, ocupado, pronto}), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        ocupado_visto = 1'b0;

        // First single-cycle op: pronto in cycle 1, ocupado never raised.
        dispara(tab[0], 0, 1'b1);
        espera(5);
        check("ocupado_simples", 64'(ocupado_visto), 64'd0);

        // Remaining table vectors, one at a time.
        for (int i = 1; i < 19; i++) begin
            dispara(tab[i], i, 1'b1);
            espera(3 * W);
        end

        // mul -3 * 7 with ocupado profile, an ignored inicio while busy and
        // operands changed after acceptance.
        v = '{3'b011, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0};
        dispara(v, 50, 1'b1);
        ocup_err = 0;
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clock);
            if (ocupado !== (k <= W + 1)) ocup_err++;
            if (k == 5) begin
                inicio        = 1'b1;
                sinalOperacao = 3'b010;
                opA           = 32'h00000001;
                opB           = 32'h00000001;
            end
            if (k == 6) inicio = 1'b0;
        end
        check("ocupado_mul", 64'(ocup_err), 64'd0);
        espera(10);

        // Back-to-back single-cycle ops, including acceptance in a pronto cycle.
        v = '{3'b000, 32'h00000003, 32'h00000006, 32'h00000002, 32'h0, 1'b0, 1'b0};
        dispara(v, 100, 1'b1);
        v = '{3'b010, 32'h0000000A, 32'h00000014, 32'h0000001E, 32'h0, 1'b0, 1'b0};
        dispara(v, 101, 1'b1);
        v = '{3'b111, 32'h80000000, 32'h00000000, 32'h00000001, 32'h0, 1'b0, 1'b0};
        dispara(v, 102, 1'b1);
        espera(5);

        // Reset in cycle 10 of a div aborts it.
        v = '{3'b100, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0, 1'b0};
        dispara(v, 200, 1'b0);
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort_dados", {resultado, resultadoAlto}, 64'd0);
        check("abort_flags", 64'({zero, erroDiv, ocupado, pronto}), 64'd0);
        v = '{3'b010, 32'h00000002, 32'h00000003, 32'h00000005, 32'h0, 1'b0, 1'b0};
        dispara(v, 201, 1'b1);
        espera(5);
        repeat (W + 8) @(posedge clock);
        #1;
        check("abort_sem_pronto", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
